ramp_neuron_layer: RTL

//  Clocked layer of ramp-response (step-no-leak SRM) neurons that feeds lateral inhibition.
//  Per gamma cycle it consumes one input volley per time step and accumulates weighted

---
 rtl/tnn_pkg.sv | 32 +++
 rtl/ramp_neuron_layer_if.sv | 26 ++
 rtl/ramp_neuron.sv | 47 ++++
 rtl/ramp_neuron_layer.sv | 118 +++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared types and sizing for the ramp-response neuron layer.
// Build-time knobs: NEURONS_PER_LAYER, LOG_TIME_PERIOD, optional LEAK_EN.
`ifndef NEURONS_PER_LAYER
`define NEURONS_PER_LAYER 4
`endif
`ifndef LOG_TIME_PERIOD
`define LOG_TIME_PERIOD 4
`endif

package tnn_pkg;
  localparam int unsigned NUM_INPUTS  = 16;
  localparam int unsigned NUM_NEURONS = `NEURONS_PER_LAYER;
  localparam int unsigned WEIGHT_W    = 3;
  localparam int unsigned POT_W       = 10;
  localparam int unsigned ACC_W       = POT_W + 1;
  localparam int unsigned LOG_TP      = `LOG_TIME_PERIOD;
  localparam int unsigned TIME_PERIOD = 1 << LOG_TP;
  localparam int unsigned TIME_W      = LOG_TP + 1;

  localparam logic [4:0] NO_WINNER = 5'b11111;

  typedef enum logic [1:0] {IDLE, INTEGRATE, FLUSH} state_t;

  typedef logic [POT_W-1:0]    pot_t;
  typedef logic [WEIGHT_W-1:0] weight_t;
  typedef logic [ACC_W-1:0]    acc_t;

  typedef struct packed {
    logic [TIME_W-1:0]      time_val;
    logic [NUM_NEURONS-1:0] spikes;
  } volley_t;
endpackage

// File: rtl/ramp_neuron_layer_if.sv
// Handshake and data bundle between the layer and its driver / winner stage.
interface ramp_neuron_layer_if;
  import tnn_pkg::*;

  logic                                      gamma_start;
  logic                                      step_valid;
  logic                                      step_ready;
  logic [NUM_INPUTS-1:0]                     in_spikes;
  logic [NUM_NEURONS*NUM_INPUTS*WEIGHT_W-1:0] weights;
  pot_t                                      threshold;
  logic                                      inhibit;
  logic [TIME_W-1:0]                         time_val;
  logic [NUM_NEURONS-1:0]                    spike_volley;
  logic                                      volley_valid;
  logic                                      gamma_done;

  modport master (
    output gamma_start, step_valid, in_spikes, weights, threshold, inhibit,
    input  step_ready, time_val, spike_volley, volley_valid, gamma_done
  );

  modport slave (
    input  gamma_start, step_valid, in_spikes, weights, threshold, inhibit,
    output step_ready, time_val, spike_volley, volley_valid, gamma_done
  );
endinterface

// File: rtl/ramp_neuron.sv
// One step-no-leak SRM neuron: saturating potential plus a fired-this-gamma flag.
// With LEAK_EN the potential decays by one per accepted step before accumulation.
module ramp_neuron
  import tnn_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_i,
  input  logic                           step_i,
  input  logic [NUM_INPUTS-1:0]          seen_i,
  input  logic [NUM_INPUTS*WEIGHT_W-1:0] w_i,
  input  pot_t                           thr_i,
  input  logic                           inhibit_i,
  output logic                           fire_c_o
);

  pot_t pot_q, pot_d, base;
  logic fired_q;
  acc_t acc;

  // Ramp response: every input seen so far this gamma keeps contributing its weight.
  always_comb begin
    acc = '0;
`ifdef LEAK_EN
    base = (pot_q != '0) ? pot_q - pot_t'(1) : '0;
`else
    base = pot_q;
`endif
    acc = acc_t'(base);
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      if (seen_i[i]) acc = acc + acc_t'(weight_t'(w_i[i*WEIGHT_W +: WEIGHT_W]));
    end
    pot_d    = acc[POT_W] ? '1 : acc[POT_W-1:0];
    fire_c_o = (pot_d >= thr_i) & ~fired_q & ~inhibit_i;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      pot_q   <= '0;
      fired_q <= 1'b0;
    end else if (step_i) begin
      pot_q   <= pot_d;
      fired_q <= fired_q | fire_c_o;
    end
  end

endmodule

// File: rtl/ramp_neuron_layer.sv
// Layer of ramp neurons: gamma FSM, step counter, sticky input mask, inhibit latch
// and registered volley outputs. LEAK_EN selects leaky neurons in ramp_neuron.
module ramp_neuron_layer
  import tnn_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  ramp_neuron_layer_if.slave  bus
);

  if (NUM_NEURONS > 32'(NO_WINNER)) begin : g_size_check
    $error("NUM_NEURONS must leave the no-winner code free");
  end

  state_t                 state_q, state_d;
  logic [LOG_TP-1:0]      cnt_q, cnt_d;
  logic [NUM_INPUTS-1:0]  seen_q, seen_d, seen_next;
  pot_t                   thr_q, thr_d;
  logic                   inh_q, inh_d;
  logic                   ready_q, ready_d;
  volley_t                out_q, out_d;
  logic                   vvalid_q, vvalid_d;
  logic                   done_q, done_d;
  logic                   clear_c, accept_c;
  logic [NUM_NEURONS-1:0] fire_c;

  assign seen_next = seen_q | bus.in_spikes;

  for (genvar n = 0; n < int'(NUM_NEURONS); n++) begin : g_neuron
    ramp_neuron u_neuron (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (clear_c),
      .step_i   (accept_c),
      .seen_i   (seen_next),
      .w_i      (bus.weights[n*NUM_INPUTS*WEIGHT_W +: NUM_INPUTS*WEIGHT_W]),
      .thr_i    (thr_q),
      .inhibit_i(inh_q),
      .fire_c_o (fire_c[n])
    );
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    thr_d    = thr_q;
    inh_d    = inh_q | bus.inhibit;
    out_d    = out_q;
    vvalid_d = 1'b0;
    done_d   = 1'b0;
    clear_c  = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.gamma_start) begin
          clear_c = 1'b1;
          cnt_d   = '0;
          seen_d  = '0;
          thr_d   = bus.threshold;
          inh_d   = 1'b0;
          state_d = INTEGRATE;
        end
      end
      INTEGRATE: begin
        accept_c = bus.step_valid & ready_q;
        if (accept_c) begin
          seen_d          = seen_next;
          out_d.time_val  = TIME_W'(cnt_q);
          out_d.spikes    = fire_c;
          vvalid_d        = 1'b1;
          cnt_d           = cnt_q + LOG_TP'(1);
          if (cnt_q == LOG_TP'(TIME_PERIOD - 1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        out_d.time_val = TIME_W'(TIME_PERIOD);
        out_d.spikes   = '0;
        done_d         = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == INTEGRATE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      seen_q   <= '0;
      thr_q    <= '0;
      inh_q    <= 1'b0;
      ready_q  <= 1'b0;
      out_q    <= '0;
      vvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      thr_q    <= thr_d;
      inh_q    <= inh_d;
      ready_q  <= ready_d;
      out_q    <= out_d;
      vvalid_q <= vvalid_d;
      done_q   <= done_d;
    end
  end

  assign bus.step_ready   = ready_q;
  assign bus.time_val     = out_q.time_val;
  assign bus.spike_volley = out_q.spikes;
  assign bus.volley_valid = vvalid_q;
  assign bus.gamma_done   = done_q;

endmodule
